// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store.
// One transaction in flight; data has priority, bounded by a starvation streak.
module sram_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_req,
    input  logic [31:0]      inst_addr,
    input  logic             inst_cancel,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_streak
);

    // Handshake: a requester holds *_req with stable fields until its
    // *_addr_ok pulse; *_data_ok is a single-cycle completion strobe.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STREAK_MAX = '1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    logic              grant_inst, grant_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_INST;
            drop_q   <= 1'b0;
            addr_q   <= 32'd0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wdata_q  <= 32'd0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        drop_d     = drop_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req && inst_req) begin
                    if ((STARVE_LIMIT != 0) && (streak_q == LIMIT)) grant_inst = 1'b1;
                    else                                            grant_data = 1'b1;
                end else if (data_req) begin
                    grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end

                if (grant_data) begin
                    owner_d = OWN_DATA;
                    addr_d  = data_addr;
                    wr_d    = data_wr;
                    size_d  = data_size;
                    wdata_d = data_wdata;
                    drop_d  = 1'b0;
                    state_d = S_ADDR;
                    // Streak only grows while fetch is actually being passed over.
                    if (!inst_req)                  streak_d = '0;
                    else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
                end else if (grant_inst) begin
                    owner_d  = OWN_INST;
                    addr_d   = inst_addr;
                    wr_d     = 1'b0;
                    size_d   = 2'd2;
                    wdata_d  = 32'd0;
                    drop_d   = 1'b0;
                    state_d  = S_ADDR;
                    streak_d = '0;
                end
            end
            S_ADDR: begin
                if (owner_q == OWN_INST && inst_cancel) drop_d = 1'b1;
                if (m_addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                if (owner_q == OWN_INST && inst_cancel) drop_d = 1'b1;
                if (m_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_req   = (state_q == S_ADDR);
    assign m_wr    = wr_q;
    assign m_size  = size_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    assign inst_addr_ok = m_req && m_addr_ok && (owner_q == OWN_INST);
    assign data_addr_ok = m_req && m_addr_ok && (owner_q == OWN_DATA);
    // A flushed fetch still completes on the bus but its data is swallowed.
    assign inst_data_ok = (state_q == S_DATA) && m_data_ok && (owner_q == OWN_INST)
                          && !drop_q && !inst_cancel;
    assign data_data_ok = (state_q == S_DATA) && m_data_ok && (owner_q == OWN_DATA);

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign dbg_streak = streak_q;

endmodule
